// File: rtl/bit_run_scheduler_if.sv
// Handshake bundle for bit_run_scheduler: four requesters' level requests
// and job words in, grant/complete pulses and per-job results out.
//   req       : per-requester job request (level)
//   din       : job words, requester i at din[i*DATA_W +: DATA_W]
//   ack       : one-hot job-accepted pulse
//   busy      : a job is in progress
//   done      : job-complete pulse, results valid alongside
//   done_id   : requester of the completed job
//   hit       : at least one run found in the completed job
//   match_cnt : run count of the completed job
//   state_out : current scheduler state
interface bit_run_scheduler_if #(
  parameter int DATA_W = 8
);

  logic [3:0]          req;
  logic [4*DATA_W-1:0] din;
  logic [3:0]          ack;
  logic                busy;
  logic                done;
  logic [1:0]          done_id;
  logic                hit;
  logic [3:0]          match_cnt;
  logic [1:0]          state_out;

  modport master (
    output req,
    output din,
    input  ack,
    input  busy,
    input  done,
    input  done_id,
    input  hit,
    input  match_cnt,
    input  state_out
  );

  modport slave (
    input  req,
    input  din,
    output ack,
    output busy,
    output done,
    output done_id,
    output hit,
    output match_cnt,
    output state_out
  );

endinterface

// File: rtl/bit_run_scheduler.sv
// Round-robin job scheduler for four requesters. A granted job word is
// scanned LSB first for non-overlapping runs of RUN_LEN ones.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : bit_run_scheduler_if.slave (req/din in; ack, busy, done,
//         done_id, hit, match_cnt, state_out out; all outputs registered)
// Build option:
//   MATCH_COUNT_EN : builds the saturating 4-bit match counter; without it
//                    match_cnt is tied to 0 and only hit is reported.
module bit_run_scheduler #(
  parameter int DATA_W  = 8,
  parameter int RUN_LEN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  bit_run_scheduler_if.slave    bus
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int RUN_W = $clog2(RUN_LEN + 1);

  localparam logic [CNT_W-1:0] BITS_END = CNT_W'(DATA_W);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_LEN - 1);

  logic [1:0]        state;
  logic [1:0]        last_grant;
  logic [1:0]        job_id;
  logic [DATA_W-1:0] word;
  logic [CNT_W-1:0]  bit_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [3:0]        ack_r;
  logic              done_r;
  logic              busy_r;
  logic              hit_r;

  logic              grant_found;
  logic [1:0]        grant_id;
  logic [1:0]        probe;
  logic              grant_ev;
  logic              consume;
  logic              match_ev;

  // Round-robin search, starting one past the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = last_grant;
    probe       = last_grant;
    for (int k = 1; k <= 4; k++) begin
      probe = last_grant + 2'(k);
      if (!grant_found && bus.req[probe]) begin
        grant_found = 1'b1;
        grant_id    = probe;
      end
    end
  end

  assign grant_ev = (state == IDLE) && grant_found;

  // SHIFT spends DATA_W edges consuming bits, then one more edge
  // publishing the finished result into DONE.
  assign consume  = (state == SHIFT) && (bit_cnt != BITS_END);
  assign match_ev = consume && word[0] && (run_cnt == RUN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      job_id     <= 2'd0;
      word       <= '0;
      bit_cnt    <= '0;
      run_cnt    <= '0;
      ack_r      <= 4'd0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      hit_r      <= 1'b0;
    end else begin
      ack_r  <= 4'd0;
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_found) begin
            state      <= SHIFT;
            busy_r     <= 1'b1;
            ack_r      <= 4'b0001 << grant_id;
            last_grant <= grant_id;
            job_id     <= grant_id;
            word       <= bus.din[grant_id*DATA_W +: DATA_W];
            bit_cnt    <= '0;
            run_cnt    <= '0;
            hit_r      <= 1'b0;
          end
        end
        SHIFT: begin
          if (consume) begin
            bit_cnt <= bit_cnt + 1'b1;
            word    <= word >> 1;
            if (!word[0]) begin
              run_cnt <= '0;
            end else if (run_cnt == RUN_LAST) begin
              // Runs do not overlap: restart after each match.
              run_cnt <= '0;
              hit_r   <= 1'b1;
            end else begin
              run_cnt <= run_cnt + 1'b1;
            end
          end else begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef MATCH_COUNT_EN
  logic [3:0] cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (grant_ev) begin
      cnt_r <= 4'd0;
    end else if (match_ev && (cnt_r != 4'hF)) begin
      cnt_r <= cnt_r + 4'd1;
    end
  end

  assign bus.match_cnt = cnt_r;
`else
  assign bus.match_cnt = 4'd0;
`endif

  assign bus.ack       = ack_r;
  assign bus.done      = done_r;
  assign bus.busy      = busy_r;
  assign bus.done_id   = job_id;
  assign bus.hit       = hit_r;
  assign bus.state_out = state;

endmodule

// File: tb/tb_bit_run_scheduler.sv
// Self-checking bench for bit_run_scheduler: directed jobs plus random
// request/data traffic against a cycle-level reference model.
module tb_bit_run_scheduler;

  localparam int DW = 8;
  localparam int RL = 3;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   tcyc;

  bit_run_scheduler_if #(.DATA_W(DW)) bus ();

  bit_run_scheduler #(
    .DATA_W  (DW),
    .RUN_LEN (RL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, tcyc);
    end
  endfunction

  // Each maximal run of L ones yields floor(L/RL) non-overlapping matches.
  function automatic int runs(logic [DW-1:0] w);
    int total;
    int len;
    total = 0;
    len   = 0;
    for (int i = 0; i <= DW; i++) begin
      if (i < DW && w[i]) begin
        len++;
      end else begin
        total += len / RL;
        len = 0;
      end
    end
    return total;
  endfunction

  function automatic int exp_cnt(int r);
`ifdef MATCH_COUNT_EN
    return (r > 15) ? 15 : r;
`else
    return 0 * r;
`endif
  endfunction

  // Reference model: job timeline measured in edges since the grant.
  int         mcyc;
  int         g_cyc;
  bit         have;
  bit         mvalid;
  int         m_last;
  int         m_id;
  int         m_hit;
  int         m_cnt;
  logic [3:0] e_ack;
  int         e_state;
  int         e_done;

  initial begin
    mcyc = 0; g_cyc = 0; have = 0; mvalid = 0; m_last = 3; m_id = 0;
    m_hit = 0; m_cnt = 0; e_ack = 0; e_state = 0; e_done = 0;
  end

  always @(posedge clk) begin
    int off;
    int pick;
    bit found;
    logic [DW-1:0] w;
    mcyc++;
    if (rst) begin
      m_last = 3; have = 0; m_id = 0; m_hit = 0; m_cnt = 0;
      e_ack = 0; e_state = 0; e_done = 0; mvalid = 1;
    end else begin
      if (e_state == 0 && bus.req != 4'd0) begin
        found = 0;
        pick  = 0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && bus.req[(m_last + k) % 4]) begin
            found = 1;
            pick  = (m_last + k) % 4;
          end
        end
        m_last = pick;
        m_id   = pick;
        have   = 1;
        g_cyc  = mcyc;
        w      = bus.din[pick*DW +: DW];
        m_hit  = (runs(w) > 0) ? 1 : 0;
        m_cnt  = exp_cnt(runs(w));
      end
      e_ack = 0; e_state = 0; e_done = 0;
      if (have) begin
        off = mcyc - g_cyc;
        if (off == 0) e_ack = 4'b0001 << m_id;
        if (off <= DW) e_state = 1;
        else if (off == DW + 1) e_state = 2;
        e_done = (off == DW + 1) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mvalid) begin
      chk("ack", int'(bus.ack), int'(e_ack));
      chk("done", int'(bus.done), e_done);
      chk("busy", int'(bus.busy), (e_state != 0) ? 1 : 0);
      chk("state_out", int'(bus.state_out), e_state);
      chk("done_id", int'(bus.done_id), m_id);
      if (e_state != 1) begin
        chk("hit", int'(bus.hit), m_hit);
        chk("match_cnt", int'(bus.match_cnt), m_cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    tcyc++;
    bus.req = bus.req & ~bus.ack;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bus.req != 4'd0 || bus.busy) && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", (n < 300) ? 1 : 0, 1);
    step();
    step();
  endtask

  task automatic run_one(string nm, int id, logic [DW-1:0] w,
                         int xhit, int xcnt);
    int n;
    bus.din[id*DW +: DW] = w;
    bus.req[id] = 1'b1;
    n = 0;
    while (bus.ack == 4'd0 && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_ack"}, int'(bus.ack), 1 << id);
    n = 0;
    while (!bus.done && n < 30) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, n, DW + 1);
    chk({nm, "_done_id"}, int'(bus.done_id), id);
    chk({nm, "_hit"}, int'(bus.hit), xhit);
    chk({nm, "_match_cnt"}, int'(bus.match_cnt), xcnt);
    step();
    step();
    chk({nm, "_hold_hit"}, int'(bus.hit), xhit);
    chk({nm, "_hold_state"}, int'(bus.state_out), 0);
  endtask

  initial begin
    int n;
    int seen;
    int t_done;
    int t_ack;
    logic [3:0] order [4];
    tests = 0; fails = 0; tcyc = 0;
    rst = 1'b1;
    bus.req = 4'd0;
    bus.din = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_state", int'(bus.state_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_done_id", int'(bus.done_id), 0);
    chk("rst_hit", int'(bus.hit), 0);
    chk("rst_match", int'(bus.match_cnt), 0);
    rst = 1'b0;
    step();

    chk("model_07", runs(8'h07), 1);
    chk("model_FF", runs(8'hFF), 2);
    chk("model_DB", runs(8'hDB), 0);

    run_one("job07", 0, 8'h07, 1, exp_cnt(1));
    run_one("jobFF", 2, 8'hFF, 1, exp_cnt(2));
    run_one("jobDB", 3, 8'hDB, 0, 0);
    drain();

    bus.din = $urandom;
    bus.req = 4'b1111;
    seen = 0;
    n = 0;
    while (seen < 4 && n < 100) begin
      step();
      n++;
      if (bus.ack != 4'd0) begin
        order[seen] = bus.ack;
        seen++;
      end
    end
    chk("rr_count", seen, 4);
    chk("rr_0", (seen > 0) ? int'(order[0]) : 0, 1);
    chk("rr_1", (seen > 1) ? int'(order[1]) : 0, 2);
    chk("rr_2", (seen > 2) ? int'(order[2]) : 0, 4);
    chk("rr_3", (seen > 3) ? int'(order[3]) : 0, 8);
    drain();

    bus.req = 4'b0010;
    n = 0;
    while (bus.ack == 4'd0 && n < 20) begin
      step();
      n++;
    end
    chk("mid_rst_ack", int'(bus.ack), 2);
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk("mid_rst_state", int'(bus.state_out), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus.done) seen++;
    end
    chk("mid_rst_no_done", seen, 0);
    bus.req = 4'b1111;
    n = 0;
    while (bus.ack == 4'd0 && n < 20) begin
      step();
      n++;
    end
    chk("mid_rst_next_grant", int'(bus.ack), 1);
    drain();

    bus.din = $urandom;
    bus.req = 4'b0001;
    n = 0;
    while (bus.ack == 4'd0 && n < 20) begin
      step();
      n++;
    end
    chk("busy_req_first", int'(bus.ack), 1);
    step(); step(); step();
    bus.req[1] = 1'b1;
    t_done = -1;
    t_ack  = -1;
    n = 0;
    while (t_ack < 0 && n < 40) begin
      step();
      n++;
      if (bus.done) t_done = tcyc;
      if (bus.ack != 4'd0) begin
        t_ack = tcyc;
        chk("busy_req_ack", int'(bus.ack), 2);
      end
    end
    chk("busy_req_seen", (t_done >= 0 && t_ack >= 0) ? 1 : 0, 1);
    chk("busy_req_gap", t_ack - t_done, 2);
    drain();

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0)
        bus.req = bus.req | 4'($urandom_range(0, 15));
      bus.din = $urandom;
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bit_run_scheduler.md
BIT_RUN_SCHEDULER -- requirements
Module: bit_run_scheduler

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; there SHALL be no other clock or reset.
REQ-002 The module SHALL have parameter DATA_W, default 8, giving the bits per job.
REQ-003 The module SHALL have parameter RUN_LEN, default 3, giving the consecutive-ones run length that counts as one match (legal range 2..DATA_W).
REQ-004 The ports SHALL be:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  4  per-requester job request, level.
- din  input  4*DATA_W  job words; requester i at din[i*DATA_W +: DATA_W].
- ack  output  4  one-hot job-accepted pulse.
- busy  output  1  job in progress (state not IDLE).
- done  output  1  job-complete pulse.
- done_id  output  2  requester of the completed job.
- hit  output  1  at least one match in the completed job.
- match_cnt  output  4  match count of the completed job.
- state_out  output  2  current FSM state.

Function
REQ-005 The FSM SHALL have the states IDLE=2'b00, SHIFT=2'b01 and DONE=2'b10; 2'b11 SHALL go to IDLE on the next edge.
REQ-006 In IDLE with req!=0, the block SHALL on the next edge:
- grant one requester round-robin, searching upward from (last_grant+1) mod 4;
- latch that requester's din word and id;
- clear the run counter, the match counter and hit;
- drive ack one-hot for exactly one cycle;
- enter SHIFT.
REQ-007 In IDLE with req==0, the block SHALL hold state and outputs.
REQ-008 In SHIFT, each edge SHALL consume one latched bit, LSB first; after DATA_W edges the block SHALL enter DONE.
REQ-009 Run detection per consumed bit:
- bit=0: run counter <= 0.
- bit=1 with run counter == RUN_LEN-1: count one match, set hit, run counter <= 0 (non-overlapping).
- bit=1 otherwise: run counter +1.
REQ-010 match_cnt SHALL saturate at 15.
REQ-011 In DONE, done SHALL be 1 for exactly one cycle, with done_id, hit and match_cnt valid; the next edge SHALL return to IDLE.
REQ-012 hit, match_cnt and done_id SHALL hold their values until the next grant.
REQ-013 Latency SHALL be: ack high 1 cycle after the granting edge; done high DATA_W+1 cycles after ack rises (DATA_W=8: 9 cycles).
REQ-014 req changes during SHIFT or DONE SHALL be ignored.
REQ-015 A req still asserted in IDLE SHALL be treated as a new job; a requester SHALL drop req on ack.
REQ-016 Back-to-back jobs SHALL have exactly one IDLE cycle between done and the next ack.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 rst=1 SHALL immediately force:
- state IDLE;
- ack, done, hit, match_cnt, done_id and busy to 0;
- last_grant=3, so requester 0 has first priority.
REQ-019 Reset during SHIFT or DONE SHALL abandon the job with no done pulse.

Configuration
REQ-020 With macro MATCH_COUNT_EN defined, match_cnt SHALL operate per REQ-009 and REQ-010.
REQ-021 Without MATCH_COUNT_EN, match_cnt SHALL be constant 0, its counter SHALL not be built, and hit SHALL behave unchanged.

Verification
REQ-022 Single job, full count: req=4'b0001, din[7:0]=8'h07 -> ack=0001; 9 cycles later done=1, done_id=0, hit=1, match_cnt=1.
REQ-023 Non-overlapping runs: req[2] only, word 8'hFF -> done_id=2, hit=1, match_cnt=2 (0 without MATCH_COUNT_EN).
REQ-024 No run: word 8'hDB -> hit=0, match_cnt=0.
REQ-025 Round-robin: req=4'b1111 held, each requester dropping req on its ack -> ack order 0001, 0010, 0100, 1000.
REQ-026 Reset mid-job: rst pulsed 3 cycles after ack -> state_out=00, no done, next grant to requester 0.
REQ-027 Busy-time request: req[1] rises during SHIFT of job 0 -> ignored until IDLE, then granted with one IDLE cycle gap.
